// File: rtl/ram_sp_arbiter.sv
// ram_sp_arbiter: round-robin arbiter that lets two requesters share one
// single-port asynchronous-style RAM with a bidirectional data bus.
// Each access takes one IDLE (grant) cycle plus one WRITE or READ cycle.
module ram_sp_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,

    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic [ADDR_WIDTH-1:0] ram_address,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t                state;
    logic                  last_grant;  // requester that won the previous handshake
    logic                  owner;       // requester owning the access in flight
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic                  grant;       // requester picked this cycle (valid only in IDLE)
    logic                  can_grant;
    logic                  handshake;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Round-robin pick: a lone requester always wins, a tie goes to the one not granted last.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign can_grant  = (state == IDLE) && !reset;
    assign req0_ready = can_grant && req0_valid && !grant;
    assign req1_ready = can_grant && req1_valid &&  grant;
    assign handshake  = req0_ready || req1_ready;

    assign sel_we    = grant ? req1_we    : req0_we;
    assign sel_addr  = grant ? req1_addr  : req0_addr;
    assign sel_wdata = grant ? req1_wdata : req0_wdata;

    // The bus is driven only from registered state: ram_we is high only in WRITE, where ram_oe is low.
    assign ram_data = ram_we ? lat_wdata : {DATA_WIDTH{1'bz}};

    // Access FSM with registered RAM controls and read-response capture.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            lat_wdata   <= '0;
            ram_address <= '0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_oe      <= 1'b0;
            rsp0_valid  <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp0_rdata  <= '0;
            rsp1_rdata  <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        owner       <= grant;
                        last_grant  <= grant;
                        ram_address <= sel_addr;
                        lat_wdata   <= sel_wdata;
                        ram_cs      <= 1'b1;
                        ram_we      <= sel_we;
                        ram_oe      <= !sel_we;
                        state       <= sel_we ? WRITE : READ;
                    end
                end
                WRITE: begin
                    // The RAM captures ram_data at this edge; release the bus afterwards.
                    ram_cs <= 1'b0;
                    ram_we <= 1'b0;
                    ram_oe <= 1'b0;
                    state  <= IDLE;
                end
                READ: begin
                    if (owner) begin
                        rsp1_rdata <= ram_data;
                        rsp1_valid <= 1'b1;
                    end else begin
                        rsp0_rdata <= ram_data;
                        rsp0_valid <= 1'b1;
                    end
                    ram_cs <= 1'b0;
                    ram_we <= 1'b0;
                    ram_oe <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    ram_cs <= 1'b0;
                    ram_we <= 1'b0;
                    ram_oe <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Self-checking bench for ram_sp_arbiter: a simple RAM on the shared bus,
// a transaction-level reference model checked every cycle, directed
// scenarios for the interesting corners and a randomized phase.
module tb_ram_sp_arbiter;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic          req0_we, req1_we;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic [AW-1:0] ram_address;
    wire  [DW-1:0] ram_data;
    logic          ram_cs, ram_we, ram_oe;

    logic          mem_clr;
    logic          done;
    int            n_checks;
    int            n_pass;

    ram_sp_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_we     (req0_we),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_we     (req1_we),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .rsp0_valid  (rsp0_valid),
        .rsp0_rdata  (rsp0_rdata),
        .rsp1_valid  (rsp1_valid),
        .rsp1_rdata  (rsp1_rdata),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_cs      (ram_cs),
        .ram_we      (ram_we),
        .ram_oe      (ram_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM on the bus: drives data while selected and output-enabled.
    logic [DW-1:0] tb_mem [256];
    assign ram_data = (ram_cs && ram_oe) ? tb_mem[ram_address] : {DW{1'bz}};

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
        end else if (ram_cs && ram_we) begin
            tb_mem[ram_address] <= ram_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------------------------------------------------------
    // Reference model: transaction timeline. One access may occupy the
    // RAM per cycle; a read's data shows up on rsp the cycle after it.
    // ---------------------------------------------------------------
    logic [DW-1:0] model_mem [256];

    initial begin : monitor
        logic          acc_v, acc_we, acc_owner;
        logic [AW-1:0] acc_addr;
        logic [DW-1:0] acc_wdata;
        logic          rsp_v, rsp_owner;
        logic [DW-1:0] exp_rdata [2];
        logic          last, r0, r1, win;

        for (int i = 0; i < 256; i++) model_mem[i] = '0;
        acc_v = 0; acc_we = 0; acc_owner = 0; acc_addr = '0; acc_wdata = '0;
        rsp_v = 0; rsp_owner = 0; exp_rdata[0] = '0; exp_rdata[1] = '0;
        last = 1'b1;

        @(posedge clk);
        while (!done) begin
            @(negedge clk);
            // Outputs for the cycle the model predicted last time.
            check("ram_cs", ram_cs, acc_v);
            check("ram_we", ram_we, acc_v && acc_we);
            check("ram_oe", ram_oe, acc_v && !acc_we);
            check("oe_we_excl", ram_oe & ram_we, 0);
            if (acc_v) check("ram_address", ram_address, acc_addr);
            if (acc_v && acc_we) check("ram_wdata", ram_data, acc_wdata);
            check("rsp0_valid", rsp0_valid, rsp_v && !rsp_owner);
            check("rsp1_valid", rsp1_valid, rsp_v && rsp_owner);
            check("rsp0_rdata", rsp0_rdata, exp_rdata[0]);
            check("rsp1_rdata", rsp1_rdata, exp_rdata[1]);

            // Grant decision for this cycle.
            r0 = 0; r1 = 0; win = 0;
            if (!rst && !acc_v) begin
                if (req0_valid && req1_valid) win = !last;
                else win = req1_valid;
                r0 = req0_valid && !win;
                r1 = req1_valid && win;
            end
            check("req0_ready", req0_ready, r0);
            check("req1_ready", req1_ready, r1);

            // Advance to the next cycle.
            if (rst) begin
                acc_v = 0; rsp_v = 0; last = 1'b1;
                exp_rdata[0] = '0; exp_rdata[1] = '0;
            end else begin
                rsp_v = acc_v && !acc_we;
                if (rsp_v) begin
                    rsp_owner = acc_owner;
                    exp_rdata[acc_owner] = model_mem[acc_addr];
                end
                acc_v = r0 || r1;
                if (acc_v) begin
                    acc_owner = win;
                    acc_we    = win ? req1_we    : req0_we;
                    acc_addr  = win ? req1_addr  : req0_addr;
                    acc_wdata = win ? req1_wdata : req0_wdata;
                    last      = win;
                    if (acc_we) model_mem[acc_addr] = acc_wdata;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic n, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        logic got;
        got = 1'b0;
        if (n) begin
            req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
        end else begin
            req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = n ? req1_ready : req0_ready;
            step();
        end
        if (n) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
        check("issue_grant", got, 1);
    endtask

    initial begin : stimulus
        int c0, c1;
        n_checks = 0; n_pass = 0; done = 1'b0;
        rst = 1'b1; mem_clr = 1'b1;
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        step(); step();
        rst = 1'b0; mem_clr = 1'b0;

        // Tie from reset: req0 first, then alternate, each served every 4 cycles.
        req0_valid = 1; req0_we = 1; req0_addr = 8'h01; req0_wdata = 8'h11;
        req1_valid = 1; req1_we = 1; req1_addr = 8'h02; req1_wdata = 8'h22;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("tie_ready0", req0_ready, (k % 4) == 0);
            check("tie_ready1", req1_ready, (k % 4) == 2);
            step();
        end
        req0_valid = 0; req1_valid = 0;
        step();

        // Write 0xA5 to 0x12, read it back: response two cycles after handshake cycle.
        issue(0, 1, 8'h12, 8'hA5);
        issue(0, 0, 8'h12, 8'h00);
        @(negedge clk);
        check("rd_cs_in_read", ram_cs & ram_oe, 1);
        check("rd_early_valid", rsp0_valid, 0);
        step();
        @(negedge clk);
        check("rd_valid", rsp0_valid, 1);
        check("rd_data", rsp0_rdata, 8'hA5);
        step();

        // Single requester: req1 alone, four back-to-back reads.
        c0 = 0; c1 = 0;
        req1_valid = 1; req1_we = 0; req1_addr = 8'h02;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("single_ready1", req1_ready, (k % 2) == 0);
            if (rsp0_valid) c0++;
            if (rsp1_valid) c1++;
            step();
        end
        req1_valid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp0_valid) c0++;
            if (rsp1_valid) c1++;
            step();
        end
        check("single_rsp1_count", c1, 4);
        check("single_rsp0_count", c0, 0);
        check("single_rsp1_data", rsp1_rdata, 8'h22);

        // Reset during the READ cycle aborts the response.
        issue(0, 0, 8'h12, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rstrd_cs", ram_cs, 0);
        check("rstrd_oe", ram_oe, 0);
        check("rstrd_we", ram_we, 0);
        check("rstrd_valid", rsp0_valid, 0);
        check("rstrd_rdata", rsp0_rdata, 0);
        step();

        // Abandoned request: req1 pulses valid while req0 wins, then drops.
        req0_valid = 1; req0_we = 1; req0_addr = 8'h30; req0_wdata = 8'h5C;
        req1_valid = 1; req1_we = 0; req1_addr = 8'h77;
        @(negedge clk);
        check("abandon_grant0", req0_ready, 1);
        step();
        req0_valid = 0; req1_valid = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abandon_no_access", ram_cs && (ram_address == 8'h77), 0);
            step();
        end

        // Randomized traffic over a small address window so reads hit earlier writes.
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 299) == 0);
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_we    = $urandom_range(0, 1) != 0;
            req0_addr  = AW'($urandom_range(0, 15));
            req0_wdata = DW'($urandom);
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_we    = $urandom_range(0, 1) != 0;
            req1_addr  = AW'($urandom_range(0, 15));
            req1_wdata = DW'($urandom);
            step();
        end

        rst = 0; req0_valid = 0; req1_valid = 0;
        repeat (4) step();
        done = 1'b1;
        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_sp_arbiter.md
RAM_SP_ARBITER -- requirements
Module: ram_sp_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the RAM word width in bits.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 8, giving the RAM address width in bits.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 req0_valid, req1_valid  input  1 each  requester n has an access pending.
REQ-006 req0_ready, req1_ready  output  1 each  requester n's access is accepted this cycle.
REQ-007 req0_we, req1_we  input  1 each  1 = write, 0 = read.
REQ-008 req0_addr, req1_addr  input  ADDR_WIDTH each  access address.
REQ-009 req0_wdata, req1_wdata  input  DATA_WIDTH each  write data.
REQ-010 rsp0_valid, rsp1_valid  output  1 each  read data for requester n is valid, one-cycle pulse.
REQ-011 rsp0_rdata, rsp1_rdata  output  DATA_WIDTH each  read data, held until the next read response to the same requester.
REQ-012 ram_address  output  ADDR_WIDTH  RAM address.
REQ-013 ram_data  inout  DATA_WIDTH  RAM bidirectional data bus.
REQ-014 ram_cs, ram_we, ram_oe  output  1 each  RAM chip select, write enable and output enable.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, WRITE and READ, and WRITE and READ SHALL each last exactly one cycle and then return to IDLE.
REQ-016 In IDLE with at least one reqN_valid high, the arbiter SHALL grant one requester and assert only that requester's reqN_ready, combinationally, in the same cycle.
REQ-017 The handshake SHALL complete when valid and ready are both high at a posedge, at which point the granted addr, we and wdata SHALL be latched and the FSM SHALL enter WRITE (we=1) or READ (we=0).
REQ-018 Arbitration SHALL be round-robin: a single requester SHALL always win, and when both request, the requester not granted last SHALL win.
REQ-019 The last-grant register SHALL update only on a completed handshake.
REQ-020 reqN_ready SHALL be 0 in WRITE and READ, so the peak rate is one access per 2 cycles.
REQ-021 In IDLE: ram_cs=0, ram_we=0, ram_oe=0, and ram_data SHALL be high-Z.
REQ-022 In WRITE: ram_cs=1, ram_we=1, ram_oe=0, ram_address = latched address, and ram_data SHALL be driven with the latched wdata; the RAM captures it at the posedge ending WRITE.
REQ-023 In READ: ram_cs=1, ram_we=0, ram_oe=1, ram_address = latched address, and ram_data SHALL be high-Z (the RAM drives it).
REQ-024 At the posedge ending READ, ram_data SHALL be registered into rspN_rdata of the owning requester, and rspN_valid SHALL be 1 for the following cycle only.
REQ-025 Read latency SHALL be 2 cycles from the handshake posedge to rspN_valid high.
REQ-026 The controller SHALL never drive ram_data in any state where ram_oe=1.
REQ-027 All RAM control outputs SHALL be registered or decoded from the state register only, with no combinational path from reqN inputs to ram_*.
REQ-028 A write followed by a read to the same address SHALL return the written data.
REQ-029 A request that deasserts reqN_valid before its handshake SHALL be dropped with no RAM access.

Reset
REQ-030 Reset SHALL, at posedge clk, force state=IDLE, last-grant=requester 1 (so requester 0 wins the first tie), latched registers=0, rsp0_rdata=rsp1_rdata=0, rsp0_valid=rsp1_valid=0 and ram_cs/ram_we/ram_oe=0, with ram_data high-Z.
REQ-031 Reset asserted during WRITE or READ SHALL abort the access with no rspN_valid pulse and return to IDLE on the next cycle.
REQ-032 While reset is high, reqN_ready SHALL be 0.

Verification
REQ-033 Write then read: req0 write addr 0x12 data 0xA5, then req0 read 0x12 -> ram_cs/ram_we high for 1 cycle with ram_data=0xA5; rsp0_valid pulses 2 cycles after the read handshake with rsp0_rdata=0xA5.
REQ-034 Tie: both valid from reset, req0 write 0x01/0x11, req1 write 0x02/0x22 -> grant order req0, req1, req0...; each requester receives a ready every 4 cycles.
REQ-035 Single requester: req1 alone issues 4 back-to-back reads -> ready every 2 cycles; rsp1_valid x4, no rsp0_valid.
REQ-036 Bus direction: the monitor checks each cycle that the controller drives ram_data only when ram_we=1 and ram_oe=0, and that ram_oe and ram_we are never both 1.
REQ-037 Reset mid-read: reset asserted in the READ cycle of req0 read 0x12 -> no rsp0_valid; next cycle IDLE with all ram_* controls at 0.
REQ-038 Abandoned request: req1_valid high for 1 cycle while req0 holds the grant, then dropped -> no access to req1_addr occurs.
